// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
//   Shared constants for the mesh-router port logic.
//   - Port index constants (bit positions in the 5-bit request/clear vectors).
//   - One-hot DIRECTION encodings, one per port.
//   - NUM_PORTS and a convenience vector type.
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam int PORT_L  = 4;
    localparam int PORT_R  = 3;
    localparam int PORT_U  = 2;
    localparam int PORT_D  = 1;
    localparam int PORT_PE = 0;

    localparam logic [NUM_PORTS-1:0] DIR_L  = 5'b10000;
    localparam logic [NUM_PORTS-1:0] DIR_R  = 5'b01000;
    localparam logic [NUM_PORTS-1:0] DIR_U  = 5'b00100;
    localparam logic [NUM_PORTS-1:0] DIR_D  = 5'b00010;
    localparam logic [NUM_PORTS-1:0] DIR_PE = 5'b00001;

    typedef logic [NUM_PORTS-1:0] port_vec_t;

endpackage : noc_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter with a registered priority pointer. The grant is
//   combinational: the search starts at the pointer and walks upward, wrapping
//   from N-1 to 0; the first set request wins. When en is high and something
//   was granted, the pointer moves to the position just after the winner.
// Ports
//   clk  in  1   clock
//   rst  in  1   synchronous active-high reset (pointer -> 0)
//   req  in  N   request vector
//   en   in  1   grant is being consumed this cycle
//   gnt  out N   one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
    import noc_pkg::*;
#(
    parameter int N = NUM_PORTS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   idx;
    logic [IW-1:0] win;
    logic          found;

    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            // Rotate the search origin to the pointer, wrapping past N-1.
            idx = {1'b0, ptr_q} + (IW+1)'(i);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (!found && req[idx[IW-1:0]]) begin
                found              = 1'b1;
                gnt[idx[IW-1:0]]   = 1'b1;
                win                = idx[IW-1:0];
            end
        end

        ptr_d = ptr_q;
        if (en && found) begin
            ptr_d = (win == IW'(N-1)) ? '0 : win + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/output_interface.sv
// -----------------------------------------------------------------------------
// output_interface
//   Transmit side of one mesh-router port. Requests from the five input ports
//   are masked (no U-turn back to our own direction), arbitrated round-robin,
//   and the winning flit is pushed into a small FIFO while the winner's input
//   buffer is cleared in the same cycle. The FIFO head is presented on
//   so/datao and is popped when the downstream side asserts ro.
// Ports
//   clk        in   1                clock
//   rst        in   1                synchronous active-high reset
//   req_in     in   5                requests, [4]=L [3]=R [2]=U [1]=D [0]=PE
//   data_in    in   5*DATA_WIDTH     flit k in data_in[k*DATA_WIDTH +: DATA_WIDTH]
//   buf_clear  out  5                one-hot clear to the granted input
//   so         out  1                datao valid
//   datao      out  DATA_WIDTH       FIFO head flit (0 when so=0)
//   ro         in   1                downstream ready
// -----------------------------------------------------------------------------
module output_interface
    import noc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 64,
    parameter logic [NUM_PORTS-1:0]  DIRECTION    = DIR_PE,
    parameter int                    BUFFER_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_PORTS-1:0]            buf_clear,
    output logic                            so,
    output logic [DATA_WIDTH-1:0]           datao,
    input  logic                            ro
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    port_vec_t             req_masked;
    port_vec_t             gnt;
    logic                  accept;
    logic                  pop;
    logic [DATA_WIDTH-1:0] wdata;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_masked),
        .en  (accept),
        .gnt (gnt)
    );

    always_comb begin
        req_masked = req_in & ~DIRECTION;

        // Accept only on free space as of this cycle; a same-cycle pop does
        // not open a slot, which keeps the full path off the ro input.
        accept    = (|req_masked) && (count_q < CNT_W'(BUFFER_DEPTH)) && !rst;
        buf_clear = accept ? gnt : '0;

        wdata = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt[k]) begin
                wdata = wdata | data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Outputs come from state only, never from req_in/data_in.
        so    = (count_q != '0);
        datao = so ? mem_q[rd_ptr_q] : '0;
        pop   = so && ro;

        wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule : output_interface

// File: tb/tb_output_interface.sv
module tb_output_interface;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;

    logic [4:0]      req_r,  req_pe,  req_l;
    logic [5*DW-1:0] data_r, data_pe, data_l;
    logic            ro_r,   ro_pe,   ro_l;
    logic [4:0]      bc_r,   bc_pe,   bc_l;
    logic            so_r,   so_pe,   so_l;
    logic [DW-1:0]   dout_r, dout_pe, dout_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    output_interface #(.DATA_WIDTH(DW), .DIRECTION(5'b01000), .BUFFER_DEPTH(2)) u_r (
        .clk(clk), .rst(rst), .req_in(req_r), .data_in(data_r),
        .buf_clear(bc_r), .so(so_r), .datao(dout_r), .ro(ro_r));

    output_interface #(.DATA_WIDTH(DW), .DIRECTION(5'b00001), .BUFFER_DEPTH(2)) u_pe (
        .clk(clk), .rst(rst), .req_in(req_pe), .data_in(data_pe),
        .buf_clear(bc_pe), .so(so_pe), .datao(dout_pe), .ro(ro_pe));

    output_interface #(.DATA_WIDTH(DW), .DIRECTION(5'b10000), .BUFFER_DEPTH(2)) u_l (
        .clk(clk), .rst(rst), .req_in(req_l), .data_in(data_l),
        .buf_clear(bc_l), .so(so_l), .datao(dout_l), .ro(ro_l));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          clr_cnt [5];
        int          exp_idx [8];
        logic [4:0]  eg;

        exp_idx = '{1, 2, 3, 4, 1, 2, 3, 4};
        for (int k = 0; k < 5; k++) clr_cnt[k] = 0;

        rst    = 1'b1;
        req_r  = 5'b11111; req_pe = 5'b11111; req_l = 5'b11111;
        data_r = '0; data_l = '0; data_pe = '0;
        for (int k = 0; k < 5; k++) data_pe[k*DW +: DW] = 64'h100 + 64'(k);
        ro_r = 1'b0; ro_pe = 1'b1; ro_l = 1'b1;

        // 1. reset held two cycles with all requests high
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            check("rst_so_r",   64'(so_r),   64'd0);
            check("rst_dout_r", dout_r,      64'd0);
            check("rst_bc_r",   64'(bc_r),   64'd0);
            check("rst_bc_pe",  64'(bc_pe),  64'd0);
            check("rst_so_pe",  64'(so_pe),  64'd0);
        end
        rst = 1'b0;
        req_r = '0; req_pe = '0; req_l = '0;

        // 2. single flit through the R port
        @(negedge clk);
        req_r = 5'b00001; data_r[0 +: DW] = 64'hA5; ro_r = 1'b1;
        #1;
        check("single_bc",   64'(bc_r), 64'h01);
        check("single_so0",  64'(so_r), 64'd0);
        @(negedge clk);
        req_r = 5'b00000;
        #1;
        check("single_so1",  64'(so_r), 64'd1);
        check("single_dout", dout_r,    64'hA5);
        check("single_bc0",  64'(bc_r), 64'd0);
        @(negedge clk); #1;
        check("single_so2",  64'(so_r), 64'd0);
        check("single_dz",   dout_r,    64'd0);

        // 3. round robin on the PE port, four neighbours always requesting
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_pe = 5'b11110;
            #1;
            eg = 5'b00001 << exp_idx[i];
            check("rr_gnt", 64'(bc_pe), 64'(eg));
            if (i > 0) begin
                check("rr_so",   64'(so_pe), 64'd1);
                check("rr_data", dout_pe, 64'h100 + 64'(exp_idx[i-1]));
            end
            for (int k = 0; k < 5; k++) clr_cnt[k] += int'(bc_pe[k]);
        end
        check("rr_share_pe", 64'(clr_cnt[0]), 64'd0);
        for (int k = 1; k < 5; k++) check("rr_share", 64'(clr_cnt[k]), 64'd2);
        @(negedge clk);
        req_pe = '0;
        #1;
        check("rr_last", dout_pe, 64'h104);
        @(negedge clk); #1;
        check("rr_drain", 64'(so_pe), 64'd0);

        // 4. L port ignores a request from L
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_l = 5'b10000;
            #1;
            check("uturn_bc", 64'(bc_l), 64'd0);
            check("uturn_so", 64'(so_l), 64'd0);
        end
        req_l = '0;

        // 5. back-pressure on R (pointer sits at D after test 2)
        @(negedge clk);
        data_r[4*DW +: DW] = 64'h44;
        data_r[2*DW +: DW] = 64'h22;
        data_r[0*DW +: DW] = 64'h11;
        req_r = 5'b10101; ro_r = 1'b0;
        #1;
        check("bp_g1", 64'(bc_r), 64'h04);
        @(negedge clk);
        req_r = 5'b10001;
        #1;
        check("bp_g2",   64'(bc_r), 64'h10);
        check("bp_so",   64'(so_r), 64'd1);
        check("bp_d1",   dout_r,    64'h22);
        @(negedge clk);
        req_r = 5'b00001;
        #1;
        check("bp_full", 64'(bc_r), 64'd0);
        check("bp_hold", dout_r,    64'h22);
        @(negedge clk); #1;
        check("bp_full2", 64'(bc_r), 64'd0);
        check("bp_hold2", dout_r,    64'h22);
        check("bp_so2",   64'(so_r), 64'd1);
        @(negedge clk);
        ro_r = 1'b1;
        #1;
        check("bp_fullpop", 64'(bc_r), 64'd0);
        check("bp_head",    dout_r,    64'h22);
        @(negedge clk); #1;
        check("bp_d2",  dout_r,    64'h44);
        check("bp_g3",  64'(bc_r), 64'h01);
        @(negedge clk);
        req_r = 5'b00000;
        #1;
        check("bp_d3",  dout_r,    64'h11);
        check("bp_bc0", 64'(bc_r), 64'd0);
        @(negedge clk); #1;
        check("bp_empty", 64'(so_r), 64'd0);
        check("bp_dz",    dout_r,    64'd0);

        // 6. reset with two flits queued
        @(negedge clk);
        data_r[1*DW +: DW] = 64'hD1;
        data_r[2*DW +: DW] = 64'hD2;
        req_r = 5'b00110; ro_r = 1'b0;
        #1;
        check("mr_g1", 64'(bc_r), 64'h02);
        @(negedge clk);
        req_r = 5'b00100;
        #1;
        check("mr_g2", 64'(bc_r), 64'h04);
        @(negedge clk);
        rst = 1'b1;
        req_r = 5'b10010;
        #1;
        check("mr_rst_bc", 64'(bc_r), 64'd0);
        check("mr_so",     64'(so_r), 64'd1);
        check("mr_head",   dout_r,    64'hD1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_so0",  64'(so_r), 64'd0);
        check("mr_dz",   dout_r,    64'd0);
        check("mr_ptr",  64'(bc_r), 64'h02);
        @(negedge clk);
        req_r = 5'b00000; ro_r = 1'b1;
        #1;
        check("mr_so1",  64'(so_r), 64'd1);
        check("mr_new",  dout_r,    64'hD1);
        @(negedge clk); #1;
        check("mr_end",  64'(so_r), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_output_interface
